// File: rtl/iqmap_seq_ctrl_if.sv
// Bus bundle between the IQ-map sequencer, its upstream coded-bit FIFO and the mapper.
// master = sequencer side, slave = FIFO/mapper side.
interface iqmap_seq_ctrl_if #(
    parameter int CW = 9
);
    logic           fifo_empty;
    logic           fifo_rd;
    logic [127:0]   fifo_dout;
    logic           map_valid;
    logic           map_ready;
    logic [3:0]     map_bits;
    logic [CW-1:0]  carrier_idx;
    logic           sym_start;
    logic           sym_last;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  map_ready,
        output fifo_rd,
        output map_valid,
        output map_bits,
        output carrier_idx,
        output sym_start,
        output sym_last
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output map_ready,
        input  fifo_rd,
        input  map_valid,
        input  map_bits,
        input  carrier_idx,
        input  sym_start,
        input  sym_last
    );
endinterface

// File: rtl/iqmap_seq_ctrl.sv
// One-seg IQ mapper sequencer: slices 128-bit FIFO words into QPSK/16QAM carrier groups,
// counts carriers per OFDM symbol and leaves an idle gap after each symbol.
module iqmap_seq_ctrl #(
    parameter int CARRIERS   = 384,
    parameter int GAP_CYCLES = 48,
    parameter int CW         = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               mode,
    iqmap_seq_ctrl_if.master   bus,
    output logic               busy,
    output logic               underrun
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam int             GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0]  LAST_IDX = CW'(CARRIERS - 1);
    localparam logic [GW-1:0]  GAP_LOAD = GW'(GAP_CYCLES);

    logic [2:0]     state_reg, state_next;
    logic [127:0]   sreg_reg, sreg_next;
    logic [7:0]     bits_reg, bits_next;
    logic [CW-1:0]  idx_reg, idx_next;
    logic [GW-1:0]  gap_reg, gap_next;
    logic           mode_reg, mode_next;
    logic           underrun_reg, underrun_next;

    logic [7:0]     step;
    logic           transfer;

    assign step     = mode_reg ? 8'd4 : 8'd2;
    assign transfer = (state_reg == ST_RUN) && bus.map_ready;

    always_comb begin
        state_next    = state_reg;
        sreg_next     = sreg_reg;
        bits_next     = bits_reg;
        idx_next      = idx_reg;
        gap_next      = gap_reg;
        mode_next     = mode_reg;
        underrun_next = underrun_reg;
        case (state_reg)
            ST_IDLE: begin
                mode_next = mode;
                if (enable) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!bus.fifo_empty) begin
                    state_next = ST_WAIT;
                end else if (idx_reg != '0) begin
                    // Starving in the middle of a symbol breaks the carrier timing downstream.
                    underrun_next = 1'b1;
                end
            end
            ST_WAIT: begin
                sreg_next  = bus.fifo_dout;
                bits_next  = 8'd128;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (transfer) begin
                    sreg_next = mode_reg ? (sreg_reg >> 4) : (sreg_reg >> 2);
                    bits_next = bits_reg - step;
                    if (idx_reg == LAST_IDX) begin
                        idx_next   = '0;
                        gap_next   = GAP_LOAD;
                        state_next = ST_GAP;
                    end else begin
                        idx_next = idx_reg + CW'(1);
                        if (bits_reg == step) begin
                            state_next = ST_FETCH;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_reg == GW'(1)) begin
                    if (!enable) begin
                        // Leftover bits of a partly consumed word are dropped on stop.
                        state_next = ST_IDLE;
                        bits_next  = 8'd0;
                        sreg_next  = '0;
                    end else if (bits_reg == 8'd0) begin
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_RUN;
                    end
                end else begin
                    gap_next = gap_reg - GW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            sreg_reg     <= '0;
            bits_reg     <= 8'd0;
            idx_reg      <= '0;
            gap_reg      <= '0;
            mode_reg     <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sreg_reg     <= sreg_next;
            bits_reg     <= bits_next;
            idx_reg      <= idx_next;
            gap_reg      <= gap_next;
            mode_reg     <= mode_next;
            underrun_reg <= underrun_next;
        end
    end

    // Lanes 3:2 only carry data in 16QAM; QPSK keeps them at zero.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            if (gi < 2) begin : g_low
                assign bus.map_bits[gi] = sreg_reg[gi];
            end else begin : g_high
                assign bus.map_bits[gi] = sreg_reg[gi] & mode_reg;
            end
        end
    endgenerate

    assign bus.fifo_rd     = (state_reg == ST_FETCH) && !bus.fifo_empty;
    assign bus.map_valid   = (state_reg == ST_RUN);
    assign bus.carrier_idx = idx_reg;
    assign bus.sym_start   = bus.map_valid && (idx_reg == '0);
    assign bus.sym_last    = bus.map_valid && (idx_reg == LAST_IDX);
    assign busy            = (state_reg != ST_IDLE);
    assign underrun        = underrun_reg;

endmodule

// File: tb/tb_iqmap_seq_ctrl.sv
// Directed bench for iqmap_seq_ctrl: FIFO model, transfer monitor, and linear test steps.
module tb_iqmap_seq_ctrl;
    localparam int CARRIERS = 384;
    localparam int GAPC     = 48;
    localparam int CW       = 9;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic mode;
    logic busy;
    logic underrun;

    iqmap_seq_ctrl_if #(.CW(CW)) bus ();

    iqmap_seq_ctrl #(.CARRIERS(CARRIERS), .GAP_CYCLES(GAPC), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .mode     (mode),
        .bus      (bus),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Upstream FIFO: one-cycle read latency.
    logic [127:0] fmem [0:63];
    int  wr_ptr = 0;
    int  rd_ptr = 0;
    int  rd_count = 0;
    int  rd_empty_err = 0;
    logic force_empty = 1'b0;

    assign bus.fifo_empty = force_empty || (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rd) begin
            if (bus.fifo_empty) rd_empty_err <= rd_empty_err + 1;
            bus.fifo_dout <= fmem[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
            rd_count      <= rd_count + 1;
        end
    end

    // Transfer monitor: expected bits are the queued words consumed LSB first.
    logic tb_mode = 1'b0;
    int   mon_word = 0;
    int   mon_bit  = 0;
    int   exp_idx  = 0;
    int   mon_err  = 0;

    always @(posedge clk) begin
        logic [127:0] w;
        logic [3:0]   eb;
        int           e;
        int           st;
        e = 0;
        if (rst) begin
            mon_word <= rd_ptr;
            mon_bit  <= 0;
            exp_idx  <= 0;
        end else begin
            if (bus.map_valid) begin
                if (bus.sym_start !== (bus.carrier_idx == 0)) e++;
                if (bus.sym_last !== (bus.carrier_idx == CW'(CARRIERS - 1))) e++;
            end else if (bus.sym_start !== 1'b0 || bus.sym_last !== 1'b0) begin
                e++;
            end
            if (bus.map_valid && bus.map_ready) begin
                w  = fmem[mon_word];
                st = tb_mode ? 4 : 2;
                eb = tb_mode ? w[mon_bit +: 4] : {2'b00, w[mon_bit +: 2]};
                if (bus.map_bits !== eb) e++;
                if (bus.carrier_idx !== CW'(exp_idx)) e++;
                exp_idx <= (exp_idx == CARRIERS - 1) ? 0 : exp_idx + 1;
                if (mon_bit + st == 128) begin
                    mon_bit  <= 0;
                    mon_word <= mon_word + 1;
                end else begin
                    mon_bit <= mon_bit + st;
                end
            end
        end
        mon_err <= mon_err + e;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [127:0] w);
        fmem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic wait_idx(input int idx, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.map_valid && bus.carrier_idx == CW'(idx)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output int n, output bit saw_valid);
        n = 0;
        saw_valid = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            n++;
            if (bus.map_valid) saw_valid = 1'b1;
            if (!busy) break;
        end
    endtask

    initial begin
        bit          ok;
        int          n;
        int          low;
        int          rd_at;
        int          rd_base;
        bit          sv;
        logic [3:0]  held_bits;
        logic [3:0]  exp16 [4];
        exp16 = '{4'h3, 4'hC, 4'h5, 4'hA};

        rst = 1'b1; enable = 1'b0; mode = 1'b0; bus.map_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_map_valid", bus.map_valid, 0);
        chk("rst_fifo_rd", bus.fifo_rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_map_bits", bus.map_bits, 0);
        chk("rst_carrier_idx", bus.carrier_idx, 0);
        chk("rst_sym_start", bus.sym_start, 0);
        chk("rst_sym_last", bus.sym_last, 0);
        rst = 1'b0;

        // T1/T2: QPSK, two symbols queued (6 words each).
        tb_mode = 1'b0;
        push(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32E4);
        for (int i = 1; i < 12; i++) push({$urandom, $urandom, $urandom, $urandom});
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        chk("t1_fifo_rd_cycle1", bus.fifo_rd, 1);
        chk("t1_busy", busy, 1);
        chk("t1_valid_cycle1", bus.map_valid, 0);
        @(negedge clk);
        chk("t1_valid_cycle2", bus.map_valid, 0);
        @(negedge clk);
        chk("t1_valid_cycle3", bus.map_valid, 1);
        chk("t1_sym_start", bus.sym_start, 1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            chk("t1_bits", bus.map_bits, k);
            chk("t1_idx", bus.carrier_idx, k);
        end

        wait_idx(383, 600, ok);
        chk("t2_reach_383", ok, 1);
        chk("t2_sym_last", bus.sym_last, 1);
        chk("t2_reads_sym1", rd_count, 6);
        // Words align with the symbol: 48 gap cycles, then FETCH and WAIT bubbles.
        low = 0; rd_at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.map_valid) break;
            if (bus.fifo_rd && rd_at < 0) rd_at = low;
            low++;
        end
        chk("t2_valid_low_cycles", low, GAPC + 2);
        chk("t2_gap_before_fetch", rd_at, GAPC);
        chk("t2_next_idx0", bus.carrier_idx, 0);
        chk("t2_next_sym_start", bus.sym_start, 1);

        // T4: backpressure at carrier 10.
        wait_idx(10, 20, ok);
        chk("t4_reach_10", ok, 1);
        bus.map_ready = 1'b0;
        held_bits = bus.map_bits;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_hold", {bus.map_valid, bus.carrier_idx, bus.map_bits}, {1'b1, CW'(10), held_bits});
        end
        bus.map_ready = 1'b1;
        @(negedge clk);
        chk("t4_resume_idx", bus.carrier_idx, 11);

        // T6: enable dropped mid-symbol; the symbol still completes.
        wait_idx(100, 200, ok);
        chk("t6_reach_100", ok, 1);
        enable = 1'b0;
        wait_idx(383, 400, ok);
        chk("t6_reach_383", ok, 1);
        wait_idle(100, n, sv);
        chk("t6_idle_after_gap", n, GAPC + 1);
        chk("t6_no_valid_in_gap", sv, 0);
        chk("t6_busy", busy, 0);
        chk("t6_reads_total", rd_count, 12);
        chk("mon_after_qpsk", mon_err, 0);

        // T3: 16QAM, mode change mid-run ignored.
        tb_mode = 1'b1; mode = 1'b1;
        push({112'h1111_2222_3333_4444_5555_6666_7777, 16'hA5C3});
        for (int i = 1; i < 12; i++) push({$urandom, $urandom, $urandom, $urandom});
        rd_base = rd_count;
        @(negedge clk);
        enable = 1'b1;
        wait_idx(0, 10, ok);
        chk("t3_start", ok, 1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            chk("t3_bits", bus.map_bits, exp16[k]);
        end
        wait_idx(50, 100, ok);
        mode = 1'b0;
        wait_idx(383, 500, ok);
        chk("t3_reach_383", ok, 1);
        chk("t3_reads_sym", rd_count - rd_base, 12);
        enable = 1'b0;
        wait_idle(100, n, sv);
        chk("t3_idle", busy, 0);
        chk("mon_after_qam", mon_err, 0);

        // T5: FIFO runs dry after two words of a QPSK symbol.
        tb_mode = 1'b0;
        push({$urandom, $urandom, $urandom, $urandom});
        push({$urandom, $urandom, $urandom, $urandom});
        @(negedge clk);
        enable = 1'b1;
        wait_idx(127, 200, ok);
        chk("t5_reach_127", ok, 1);
        chk("t5_no_underrun_yet", underrun, 0);
        repeat (6) @(negedge clk);
        chk("t5_underrun_set", underrun, 1);
        chk("t5_stalled_valid", bus.map_valid, 0);
        chk("t5_stalled_rd", bus.fifo_rd, 0);
        for (int i = 0; i < 4; i++) push({$urandom, $urandom, $urandom, $urandom});
        wait_idx(128, 10, ok);
        chk("t5_resume_128", ok, 1);
        chk("t5_underrun_sticky", underrun, 1);

        // RST in the middle of RUN.
        wait_idx(200, 100, ok);
        chk("t5_reach_200", ok, 1);
        rst = 1'b1; enable = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", bus.map_valid, 0);
        chk("mid_rst_underrun", underrun, 0);
        chk("mid_rst_idx", bus.carrier_idx, 0);
        chk("mid_rst_bits", bus.map_bits, 0);
        rd_base = rd_count;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_no_reads", rd_count, rd_base);
        chk("post_rst_idle", busy, 0);
        chk("mon_final", mon_err, 0);
        chk("never_read_empty", rd_empty_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
